// File: rtl/stall_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : stall_ctrl_if
//  Description : Bundles the stall-controller request, sequencer and
//                performance-counter signals.
//                master : pipeline side (drives requests, reads stall vector)
//                slave  : stall_ctrl side
//  Ports       : stallreq_from_id, stallreq_from_ex, mc_start, mc_cycles,
//                flush, cnt_clr (master -> slave)
//                stall, mc_busy, mc_done, stall_cycles (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface stall_ctrl_if #(
    parameter int CNT_W  = 6,
    parameter int PERF_W = 16
);
    logic              stallreq_from_id;
    logic              stallreq_from_ex;
    logic              mc_start;
    logic [CNT_W-1:0]  mc_cycles;
    logic              flush;
    logic              cnt_clr;
    logic [5:0]        stall;
    logic              mc_busy;
    logic              mc_done;
    logic [PERF_W-1:0] stall_cycles;

    modport master (
        output stallreq_from_id, stallreq_from_ex, mc_start, mc_cycles,
               flush, cnt_clr,
        input  stall, mc_busy, mc_done, stall_cycles
    );

    modport slave (
        input  stallreq_from_id, stallreq_from_ex, mc_start, mc_cycles,
               flush, cnt_clr,
        output stall, mc_busy, mc_done, stall_cycles
    );
endinterface
`default_nettype wire

// File: rtl/stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : stall_ctrl
//  Description : Pipeline stall controller. Merges ID/EX stall requests with
//                a multi-cycle sequencer for long EX operations and keeps a
//                saturating count of stalled cycles.
//  Ports       : clk  - core clock
//                rst  - synchronous reset, active-low
//                bus  - stall_ctrl_if.slave (requests in, stall vector,
//                       sequencer status and perf counter out)
//  Revision    : 1.0 - initial release
// ============================================================================
module stall_ctrl #(
    parameter int CNT_W  = 6,
    parameter int PERF_W = 16
) (
    input  wire logic   clk,
    input  wire logic   rst,
    stall_ctrl_if.slave bus
);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_busy  = 1'b1;

    localparam logic [5:0] c_stall_ex = 6'b001111;
    localparam logic [5:0] c_stall_id = 6'b000111;

    logic [0:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [PERF_W-1:0] r_perf;

    logic              w_busy;
    logic              w_cnt_zero;
    logic              w_accept;
    logic              w_ex_class;
    logic [5:0]        w_stall;

    assign w_busy     = (r_state == c_st_busy);
    assign w_cnt_zero = (r_cnt == '0);

    // A zero-length request is not a start; a flush in the same cycle wins.
    assign w_accept   = !w_busy && bus.mc_start && (bus.mc_cycles != '0) && !bus.flush;

    // The start cycle itself already stalls, so an N-cycle op needs only
    // N-1 further BUSY stall cycles before the done cycle.
    assign w_ex_class = bus.stallreq_from_ex || (w_busy && !w_cnt_zero) || w_accept;

    always_comb begin
        w_stall = '0;
        if (!rst || bus.flush) begin
            w_stall = '0;
        end else if (w_ex_class) begin
            w_stall = c_stall_ex;
        end else if (bus.stallreq_from_id) begin
            w_stall = c_stall_id;
        end
    end

    assign bus.stall        = w_stall;
    assign bus.mc_busy      = rst && w_busy;
    assign bus.mc_done      = rst && w_busy && w_cnt_zero && !bus.flush;
    assign bus.stall_cycles = r_perf;

    // Sequencer
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
        end else if (bus.flush) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_state <= c_st_busy;
                        r_cnt   <= bus.mc_cycles - CNT_W'(1);
                    end
                end
                c_st_busy: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Saturating stall-cycle counter; clear wins over a concurrent stall.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_perf <= '0;
        end else if (bus.cnt_clr) begin
            r_perf <= '0;
        end else if (w_stall[0] && (r_perf != '1)) begin
            r_perf <= r_perf + PERF_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stall_ctrl
//  Description : Directed self-checking bench for stall_ctrl. A second
//                instance with a 4-bit perf counter covers saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stall_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    stall_ctrl_if #(.CNT_W(6), .PERF_W(16)) u_if ();
    stall_ctrl_if #(.CNT_W(6), .PERF_W(4))  u_if4 ();

    stall_ctrl #(.CNT_W(6), .PERF_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    stall_ctrl #(.CNT_W(6), .PERF_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (u_if4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #2;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_stall"}, 32'(u_if.stall), 32'h0);
        chk({tag, "_busy"},  32'(u_if.mc_busy), 32'h0);
        chk({tag, "_done"},  32'(u_if.mc_done), 32'h0);
    endtask

    // Expects mc_start asserted in the current cycle with mc_cycles=n;
    // covers n stall cycles plus the done cycle, returns after the done edge.
    task automatic mc_body(input int n, input string tag);
        for (int i = 1; i <= n; i++) begin
            settle;
            chk({tag, "_stall"}, 32'(u_if.stall), 32'h0f);
            chk({tag, "_nodone"}, 32'(u_if.mc_done), 32'h0);
            chk({tag, "_busy"}, 32'(u_if.mc_busy), (i > 1) ? 32'h1 : 32'h0);
            tick;
        end
        settle;
        chk({tag, "_done_stall"}, 32'(u_if.stall), 32'h0);
        chk({tag, "_done_pulse"}, 32'(u_if.mc_done), 32'h1);
        chk({tag, "_done_busy"}, 32'(u_if.mc_busy), 32'h1);
        tick;
    endtask

    initial begin
        u_if.stallreq_from_id  = 1'b0;
        u_if.stallreq_from_ex  = 1'b0;
        u_if.mc_start          = 1'b0;
        u_if.mc_cycles         = 6'd0;
        u_if.flush             = 1'b0;
        u_if.cnt_clr           = 1'b0;
        u_if4.stallreq_from_id = 1'b0;
        u_if4.stallreq_from_ex = 1'b0;
        u_if4.mc_start         = 1'b0;
        u_if4.mc_cycles        = 6'd0;
        u_if4.flush            = 1'b0;
        u_if4.cnt_clr          = 1'b0;

        // Reset with every request high
        rst = 1'b0;
        u_if.stallreq_from_id = 1'b1;
        u_if.stallreq_from_ex = 1'b1;
        u_if.mc_start         = 1'b1;
        u_if.mc_cycles        = 6'd5;
        tick;
        for (int i = 0; i < 3; i++) begin
            settle;
            chk_idle("rst");
            chk("rst_perf", 32'(u_if.stall_cycles), 32'h0);
            tick;
        end
        rst = 1'b1;
        u_if.stallreq_from_id = 1'b0;
        u_if.stallreq_from_ex = 1'b0;
        u_if.mc_start         = 1'b0;
        settle;
        chk_idle("rel");
        chk("rel_perf", 32'(u_if.stall_cycles), 32'h0);
        tick;

        // Request priority in IDLE
        u_if.stallreq_from_id = 1'b1;
        settle;
        chk("prio_id", 32'(u_if.stall), 32'h07);
        tick;
        u_if.stallreq_from_ex = 1'b1;
        settle;
        chk("prio_ex", 32'(u_if.stall), 32'h0f);
        tick;
        u_if.flush = 1'b1;
        settle;
        chk("prio_flush", 32'(u_if.stall), 32'h00);
        tick;
        u_if.stallreq_from_id = 1'b0;
        u_if.stallreq_from_ex = 1'b0;
        u_if.flush            = 1'b0;

        // Clear the perf counter, then a 5-cycle op
        u_if.cnt_clr = 1'b1;
        tick;
        u_if.cnt_clr = 1'b0;
        settle;
        chk("clr_perf", 32'(u_if.stall_cycles), 32'h0);
        u_if.mc_start  = 1'b1;
        u_if.mc_cycles = 6'd5;
        mc_body(5, "mc5");
        u_if.mc_start = 1'b0;
        settle;
        chk_idle("mc5_after");
        chk("mc5_perf", 32'(u_if.stall_cycles), 32'd5);
        tick;

        // N=1
        u_if.mc_start  = 1'b1;
        u_if.mc_cycles = 6'd1;
        mc_body(1, "mc1");
        u_if.mc_start = 1'b0;
        settle;
        chk_idle("mc1_after");
        tick;

        // N=0 is ignored
        u_if.mc_start  = 1'b1;
        u_if.mc_cycles = 6'd0;
        for (int i = 0; i < 3; i++) begin
            settle;
            chk_idle("mc0");
            tick;
        end
        u_if.mc_start = 1'b0;

        // N=63
        u_if.mc_start  = 1'b1;
        u_if.mc_cycles = 6'd63;
        mc_body(63, "mc63");
        u_if.mc_start = 1'b0;
        settle;
        chk_idle("mc63_after");
        tick;

        // Back-to-back: start held across the done cycle re-launches
        u_if.mc_start  = 1'b1;
        u_if.mc_cycles = 6'd2;
        mc_body(2, "b2b_a");
        u_if.mc_cycles = 6'd3;
        mc_body(3, "b2b_b");
        u_if.mc_start = 1'b0;
        settle;
        chk_idle("b2b_after");
        tick;

        // Flush at 4th stall cycle of a 10-cycle op
        u_if.mc_start  = 1'b1;
        u_if.mc_cycles = 6'd10;
        for (int i = 0; i < 3; i++) begin
            settle;
            chk("abf_stall", 32'(u_if.stall), 32'h0f);
            tick;
        end
        u_if.flush = 1'b1;
        settle;
        chk("abf_flush_stall", 32'(u_if.stall), 32'h0);
        chk("abf_flush_done", 32'(u_if.mc_done), 32'h0);
        tick;
        u_if.flush    = 1'b0;
        u_if.mc_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle;
            chk_idle("abf_after");
            tick;
        end

        // Reset at 4th stall cycle of a 10-cycle op
        u_if.mc_start  = 1'b1;
        u_if.mc_cycles = 6'd10;
        for (int i = 0; i < 3; i++) begin
            settle;
            chk("abr_stall", 32'(u_if.stall), 32'h0f);
            tick;
        end
        rst = 1'b0;
        settle;
        chk_idle("abr_rst");
        tick;
        rst           = 1'b1;
        u_if.mc_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle;
            chk_idle("abr_after");
            tick;
        end
        chk("abr_perf", 32'(u_if.stall_cycles), 32'h0);

        // Flush in the done cycle suppresses mc_done
        u_if.mc_start  = 1'b1;
        u_if.mc_cycles = 6'd2;
        tick;
        tick;
        u_if.flush = 1'b1;
        settle;
        chk("fdone_done", 32'(u_if.mc_done), 32'h0);
        chk("fdone_stall", 32'(u_if.stall), 32'h0);
        tick;
        u_if.flush    = 1'b0;
        u_if.mc_start = 1'b0;
        settle;
        chk_idle("fdone_after");
        tick;

        // Saturation on the 4-bit counter instance
        u_if4.stallreq_from_ex = 1'b1;
        for (int i = 0; i < 20; i++) tick;
        settle;
        chk("sat_15", 32'(u_if4.stall_cycles), 32'd15);
        u_if4.stallreq_from_ex = 1'b0;
        u_if4.cnt_clr          = 1'b1;
        tick;
        u_if4.cnt_clr = 1'b0;
        settle;
        chk("sat_clr", 32'(u_if4.stall_cycles), 32'd0);
        u_if4.stallreq_from_ex = 1'b1;
        for (int i = 0; i < 3; i++) tick;
        settle;
        chk("sat_3", 32'(u_if4.stall_cycles), 32'd3);
        u_if4.cnt_clr = 1'b1;
        tick;
        u_if4.cnt_clr          = 1'b0;
        u_if4.stallreq_from_ex = 1'b0;
        settle;
        chk("sat_clr_stall", 32'(u_if4.stall_cycles), 32'd0);
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
